// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings and
// 32-bit constants used by the divide special cases.
package rv32m_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned PROD_W  = 2 * XLEN + 2;

   localparam logic [OP_W-1:0] MDU_MUL    = 3'b000;
   localparam logic [OP_W-1:0] MDU_MULH   = 3'b001;
   localparam logic [OP_W-1:0] MDU_MULHSU = 3'b010;
   localparam logic [OP_W-1:0] MDU_MULHU  = 3'b011;
   localparam logic [OP_W-1:0] MDU_DIV    = 3'b100;
   localparam logic [OP_W-1:0] MDU_DIVU   = 3'b101;
   localparam logic [OP_W-1:0] MDU_REM    = 3'b110;
   localparam logic [OP_W-1:0] MDU_REMU   = 3'b111;

   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv32m_div.sv
// Combinational 32-bit divider: restoring division on operand magnitudes,
// sign fix-up, then the RISC-V divide-by-zero and overflow results.
module rv32m_div
   import rv32m_pkg::*;
(
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            is_signed,
   output logic [XLEN-1:0] quotient_c,
   output logic [XLEN-1:0] remainder_c
);

   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] quo_mag;
   logic [XLEN-1:0] rem_mag;
   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;
   logic            div_zero;
   logic            overflow;

   always_comb begin
      a_neg    = is_signed & dividend[XLEN-1];
      b_neg    = is_signed & divisor[XLEN-1];
      a_mag    = a_neg ? -dividend : dividend;
      b_mag    = b_neg ? -divisor  : divisor;
      div_zero = (divisor == '0);
      overflow = is_signed & (dividend == INT_MIN) & (divisor == ALL_ONES);

      quo_mag = '0;
      rem_mag = '0;
      trial   = '0;
      diff    = '0;
      // One quotient bit per iteration, MSB first.
      for (int i = XLEN - 1; i >= 0; i--) begin
         trial = {rem_mag, a_mag[5'(i)]};
         diff  = trial - {1'b0, b_mag};
         if (trial >= {1'b0, b_mag}) begin
            rem_mag        = diff[XLEN-1:0];
            quo_mag[5'(i)] = 1'b1;
         end else begin
            rem_mag = trial[XLEN-1:0];
         end
      end

      quotient_c  = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
      remainder_c = a_neg ? -rem_mag : rem_mag;

      if (div_zero) begin
         quotient_c  = ALL_ONES;
         remainder_c = dividend;
      end else if (overflow) begin
         quotient_c  = INT_MIN;
         remainder_c = '0;
      end
   end

endmodule

// File: rtl/rv32m_mdu.sv
// RV32M multiply/divide unit: single-cycle combinational datapath feeding
// one result register, one operation accepted per clock.
module rv32m_mdu
   import rv32m_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [OP_W-1:0] mdu_op,
   output logic [XLEN-1:0] mdu_result
);

   logic                     rs1_signed;
   logic                     rs2_signed;
   logic signed [XLEN:0]     rs1_ext;
   logic signed [XLEN:0]     rs2_ext;
   logic signed [PROD_W-1:0] product;
   logic [1:0]               unused_prod_top;
   logic [XLEN-1:0]          quotient_c;
   logic [XLEN-1:0]          remainder_c;
   logic [XLEN-1:0]          result_c;

   // Operand extension: only MULH/MULHSU treat rs1 as signed, only MULH rs2.
   always_comb begin
      rs1_signed = (mdu_op == MDU_MULH) | (mdu_op == MDU_MULHSU);
      rs2_signed = (mdu_op == MDU_MULH);
      rs1_ext    = {rs1_signed & rs1[XLEN-1], rs1};
      rs2_ext    = {rs2_signed & rs2[XLEN-1], rs2};
      product    = PROD_W'(rs1_ext) * PROD_W'(rs2_ext);
   end

   assign unused_prod_top = product[PROD_W-1:2*XLEN];

   // DIV and REM are the signed forms (funct3 bit 0 clear).
   rv32m_div u_div (
      .dividend    (rs1),
      .divisor     (rs2),
      .is_signed   (~mdu_op[0]),
      .quotient_c  (quotient_c),
      .remainder_c (remainder_c)
   );

   always_comb begin
      result_c = '0;
      case (mdu_op)
         MDU_MUL:                        result_c = product[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: result_c = product[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:              result_c = quotient_c;
         MDU_REM, MDU_REMU:              result_c = remainder_c;
         default:                        result_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mdu_result <= '0;
      end else begin
         mdu_result <= result_c;
      end
   end

endmodule

// File: tb/tb_rv32m_mdu.sv
// Bench for rv32m_mdu: directed vector table, reset/hold sequences, and
// random operations checked against a plain-arithmetic reference model.
module tb_rv32m_mdu;

   logic        clk;
   logic        rst;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [2:0]  mdu_op;
   logic [31:0] mdu_result;

   int checks;
   int errors;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   rv32m_mdu dut (
      .clk        (clk),
      .rst        (rst),
      .rs1        (rs1),
      .rs2        (rs2),
      .mdu_op     (mdu_op),
      .mdu_result (mdu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: RV32M semantics via 64-bit integer arithmetic.
   function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      longint p;
      int     ia;
      int     ib;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      ia = int'(a);
      ib = int'(b);
      p  = 0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      mdu_op = op;
      rs1    = a;
      rs2    = b;
   endtask

   task automatic compare(input string name, input logic [31:0] exp);
      checks++;
      if (mdu_result !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, mdu_result, exp);
      end
   endtask

   // Drive at the falling edge, sample 1ns after the next rising edge.
   task automatic step(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input string name);
      drive(op, a, b);
      @(posedge clk);
      #1;
      compare(name, exp);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      vec_t        vecs[$];
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      rs1    = 32'h0;
      rs2    = 32'h0;
      mdu_op = 3'd0;

      @(posedge clk);
      @(posedge clk);
      #1;
      compare("reset_value", 32'h0);

      vecs.push_back('{3'd0, 32'd3,          32'd4,          32'd12,         "mul_3x4"});
      vecs.push_back('{3'd0, 32'd7,          32'd5,          32'd35,         "mul_7x5"});
      vecs.push_back('{3'd0, 32'd10,         32'd20,         32'd200,        "mul_10x20"});
      vecs.push_back('{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   "mulh_m1m1"});
      vecs.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   "mulhu_max"});
      vecs.push_back('{3'd2, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF,   "mulhsu_m1x2"});
      vecs.push_back('{3'd0, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFE,   "mul_m1x2"});
      vecs.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "div_m7_2"});
      vecs.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "rem_m7_2"});
      vecs.push_back('{3'd5, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   "divu_big_2"});
      vecs.push_back('{3'd7, 32'hFFFFFFF9,   32'd2,          32'h00000001,   "remu_big_2"});
      vecs.push_back('{3'd4, 32'h00001234,   32'd0,          32'hFFFFFFFF,   "div_by_zero"});
      vecs.push_back('{3'd5, 32'h00001234,   32'd0,          32'hFFFFFFFF,   "divu_by_zero"});
      vecs.push_back('{3'd6, 32'h00001234,   32'd0,          32'h00001234,   "rem_by_zero"});
      vecs.push_back('{3'd7, 32'h00001234,   32'd0,          32'h00001234,   "remu_by_zero"});
      vecs.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "div_overflow"});
      vecs.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   "rem_overflow"});
      vecs.push_back('{3'd4, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   "div_7_m2"});
      vecs.push_back('{3'd6, 32'd7,          32'hFFFFFFFE,   32'h00000001,   "rem_7_m2"});

      drive(3'd0, 32'd0, 32'd0);
      rst = 1'b0;
      foreach (vecs[i]) begin
         step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      end

      // Result must hold while inputs change between edges.
      step(3'd0, 32'd6, 32'd7, 32'd42, "hold_setup");
      @(negedge clk);
      mdu_op = 3'd4;
      rs1    = 32'd100;
      rs2    = 32'd3;
      #2;
      compare("hold_between_edges", 32'd42);
      @(posedge clk);
      #1;
      compare("hold_next_edge", 32'd33);

      // Reset in the middle of a stream, then immediate recovery.
      drive(3'd0, 32'd3, 32'd4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      compare("reset_mid_stream", 32'h0);
      drive(3'd0, 32'd9, 32'd9);
      rst = 1'b0;
      @(posedge clk);
      #1;
      compare("first_after_reset", 32'd81);

      for (int n = 0; n < 400; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         step(op, a, b, ref_mdu(op, a, b), $sformatf("rand_op%0d_%h_%h", op, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
